// File: rtl/ctrl_isa_pkg.sv
// ISA constants for the 32-bit, 5-bit-opcode decode stage: opcodes, branch/jump
// kinds, instruction field positions and the decoded control bundle.
package ctrl_isa_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;
  localparam int IMM_HI   = 16;
  localparam int TGT_HI   = 26;

  typedef enum logic [1:0] {BR_NONE, BR_BNE, BR_BLT, BR_BEX} br_kind_e;
  typedef enum logic [1:0] {JMP_NONE, JMP_J, JMP_JAL, JMP_JR} jmp_kind_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [4:0]  alu_op;
    br_kind_e    br_kind;
    jmp_kind_e   jmp_kind;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [26:0] target;
    logic        illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_if.sv
// Fetch-side and execute-side handshake plus the registered control bundle.
interface ctrl_decode_if #(parameter int PC_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_alu_src;
  logic [4:0]      out_alu_op;
  logic [1:0]      out_br_kind;
  logic [1:0]      out_jmp_kind;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [31:0]     out_imm;
  logic [26:0]     out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_reg_write, out_mem_read, out_mem_write,
           out_alu_src, out_alu_op, out_br_kind, out_jmp_kind, out_rd, out_rs, out_rt,
           out_imm, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_reg_write, out_mem_read, out_mem_write,
           out_alu_src, out_alu_op, out_br_kind, out_jmp_kind, out_rd, out_rs, out_rt,
           out_imm, out_target, out_illegal
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Combinational instruction decoder: instruction word to unregistered control
// bundle, with implicit-register resolution and r0 write suppression.
module ctrl_decode_comb
  import ctrl_isa_pkg::*;
#(
  parameter int unsigned STATUS_REG = 30,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t bundle_o,
  output logic [4:0]   rs_o,
  output logic [4:0]   rt_o
);

  logic [4:0] opcode, f_rd, f_rs, f_rt, f_aluop;
  ctrl_bundle_t b;

  assign opcode  = instr_i[OPC_HI:OPC_LO];
  assign f_rd    = instr_i[RD_HI:RD_LO];
  assign f_rs    = instr_i[RS_HI:RS_LO];
  assign f_rt    = instr_i[RT_HI:RT_LO];
  assign f_aluop = instr_i[ALUOP_HI:ALUOP_LO];

  always_comb begin
    b        = '0;
    b.imm    = {{(31-IMM_HI){instr_i[IMM_HI]}}, instr_i[IMM_HI:0]};
    b.target = instr_i[TGT_HI:0];
    case (opcode)
      OP_ALU: begin
        b.rd = f_rd; b.rs = f_rs; b.rt = f_rt;
        b.alu_op = f_aluop; b.reg_write = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        b.rd = f_rd; b.rs = f_rs;
        b.alu_src = 1'b1; b.reg_write = 1'b1;
        b.mem_read = (opcode == OP_LW);
      end
      OP_SW: begin
        b.rs = f_rs; b.rt = f_rd;
        b.alu_src = 1'b1; b.mem_write = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        b.rs = f_rd; b.rt = f_rs; b.alu_op = 5'b00001;
        b.br_kind = (opcode == OP_BNE) ? BR_BNE : BR_BLT;
      end
      OP_J:   b.jmp_kind = JMP_J;
      OP_JAL: begin
        b.jmp_kind = JMP_JAL; b.rd = 5'(LINK_REG); b.reg_write = 1'b1;
      end
      OP_JR: begin
        b.jmp_kind = JMP_JR; b.rs = f_rd;
      end
      OP_BEX: begin
        b.br_kind = BR_BEX; b.rs = 5'(STATUS_REG);
      end
      OP_SETX: begin
        b.rd = 5'(STATUS_REG); b.reg_write = 1'b1;
        b.imm = {5'd0, instr_i[TGT_HI:0]};
      end
      default: b.illegal = 1'b1;
    endcase
    // r0 is hardwired; never let a write to it reach the register file
    if (b.rd == 5'd0) b.reg_write = 1'b0;
  end

  assign bundle_o = b;
  assign rs_o     = b.rs;
  assign rt_o     = b.rt;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage with valid/ready on both sides, load-use bubble and flush.
// Optional CTRL_DECODE_PERF_EN adds saturating bubble/flush counters.
module ctrl_decode_stage
  import ctrl_isa_pkg::*;
#(
  parameter int          PC_W         = 32,
  parameter int unsigned STATUS_REG   = 30,
  parameter int unsigned LINK_REG     = 31,
  parameter int          HAZARD_CHECK = 1
) (
  input  logic clock,
  input  logic reset_n,
  ctrl_decode_if.slave bus
`ifdef CTRL_DECODE_PERF_EN
  ,
  output logic [15:0] perf_bubbles,
  output logic [15:0] perf_flushes
`endif
);

  ctrl_bundle_t    dec, bundle_q;
  logic [4:0]      dec_rs, dec_rt;
  logic [PC_W-1:0] pc_q;
  logic            valid_q, valid_d;
  logic            hazard, accept, in_ready;

  ctrl_decode_comb #(.STATUS_REG(STATUS_REG), .LINK_REG(LINK_REG)) u_dec (
    .instr_i  (bus.in_instr),
    .bundle_o (dec),
    .rs_o     (dec_rs),
    .rt_o     (dec_rt)
  );

  // a load still in flight this cycle cannot forward to an immediate consumer
  assign hazard = (HAZARD_CHECK != 0) && valid_q && bus.out_ready && bundle_q.mem_read &&
                  (bundle_q.rd != 5'd0) && bus.in_valid &&
                  ((dec_rs == bundle_q.rd) || (dec_rt == bundle_q.rd));

  assign in_ready = reset_n && !bus.flush && (!valid_q || bus.out_ready) && !hazard;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (bus.flush)          valid_d = 1'b0;
    else if (accept)        valid_d = 1'b1;
    else if (bus.out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        bundle_q <= dec;
        pc_q     <= bus.in_pc;
      end
    end
  end

`ifdef CTRL_DECODE_PERF_EN
  logic [15:0] bubbles_q, bubbles_d, flushes_q, flushes_d;

  always_comb begin
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if (hazard && !bus.flush && bubbles_q != 16'hFFFF) bubbles_d = bubbles_q + 16'd1;
    if (bus.flush && valid_q && flushes_q != 16'hFFFF) flushes_d = flushes_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`endif

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_reg_write = bundle_q.reg_write;
  assign bus.out_mem_read  = bundle_q.mem_read;
  assign bus.out_mem_write = bundle_q.mem_write;
  assign bus.out_alu_src   = bundle_q.alu_src;
  assign bus.out_alu_op    = bundle_q.alu_op;
  assign bus.out_br_kind   = bundle_q.br_kind;
  assign bus.out_jmp_kind  = bundle_q.jmp_kind;
  assign bus.out_rd        = bundle_q.rd;
  assign bus.out_rs        = bundle_q.rs;
  assign bus.out_rt        = bundle_q.rt;
  assign bus.out_imm       = bundle_q.imm;
  assign bus.out_target    = bundle_q.target;
  assign bus.out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: decode vector table through a
// scoreboard, plus load-use, backpressure/flush and reset corner sequences.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        rw, mr, mw, as;
    logic [4:0]  aop;
    logic [1:0]  br, jk;
    logic [4:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [26:0] tgt;
    logic        ill;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic        rw, mr, mw, as;
    logic [4:0]  aop;
    logic [1:0]  br, jk;
    logic [4:0]  rd, rs, rt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  logic clock, reset_n;
  ctrl_decode_if #(.PC_W(32)) bus ();
`ifdef CTRL_DECODE_PERF_EN
  logic [15:0] perf_bubbles, perf_flushes;
`endif

  ctrl_decode_stage #(.PC_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CTRL_DECODE_PERF_EN
    ,
    .perf_bubbles (perf_bubbles),
    .perf_flushes (perf_flushes)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bundle_t q[$];
  bundle_t cur_exp;
  vec_t vecs[17];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [11:0] low);
    return {op, rd, rs, rt, low};
  endfunction

  function automatic bundle_t to_exp(input vec_t v, input logic [31:0] pc);
    bundle_t b;
    b.pc = pc; b.rw = v.rw; b.mr = v.mr; b.mw = v.mw; b.as = v.as;
    b.aop = v.aop; b.br = v.br; b.jk = v.jk;
    b.rd = v.rd; b.rs = v.rs; b.rt = v.rt;
    b.imm = v.imm; b.tgt = v.instr[26:0]; b.ill = v.ill;
    return b;
  endfunction

  function automatic bundle_t act();
    bundle_t b;
    b.pc = bus.out_pc; b.rw = bus.out_reg_write; b.mr = bus.out_mem_read;
    b.mw = bus.out_mem_write; b.as = bus.out_alu_src; b.aop = bus.out_alu_op;
    b.br = bus.out_br_kind; b.jk = bus.out_jmp_kind;
    b.rd = bus.out_rd; b.rs = bus.out_rs; b.rt = bus.out_rt;
    b.imm = bus.out_imm; b.tgt = bus.out_target; b.ill = bus.out_illegal;
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // scoreboard: compare on consume, drop on flush, record on accept
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.flush && bus.out_valid) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got bundle pc=%h, expected none", bus.out_pc);
        end else begin
          chk("sb_bundle", 128'(act()), 128'(q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bundle_t e);
    int n;
    cur_exp = e;
    bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc;
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      n++;
      if (n >= 20) begin
        n_checks++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vec_t lw5, add_a, add_b, addi9, instb, radd;
    bundle_t e_a;
    //          instr                         rw mr mw as aop br jk rd  rs  rt  imm            ill
    vecs[0]  = '{mk(0, 3, 2, 4, 12'h000),      1, 0, 0, 0, 0, 0, 0, 3,  2,  4,  32'h00004000, 0};
    vecs[1]  = '{mk(0, 7, 8, 9, 12'h004),      1, 0, 0, 0, 1, 0, 0, 7,  8,  9,  32'h00009004, 0};
    vecs[2]  = '{mk(0, 0, 2, 3, 12'h000),      0, 0, 0, 0, 0, 0, 0, 0,  2,  3,  32'h00003000, 0};
    vecs[3]  = '{mk(5, 4, 1, 31, 12'hFFF),     1, 0, 0, 1, 0, 0, 0, 4,  1,  0,  32'hFFFFFFFF, 0};
    vecs[4]  = '{mk(7, 6, 2, 0, 12'h004),      0, 0, 1, 1, 0, 0, 0, 0,  2,  6,  32'h00000004, 0};
    vecs[5]  = '{mk(2, 3, 4, 0, 12'h002),      0, 0, 0, 0, 1, 1, 0, 0,  3,  4,  32'h00000002, 0};
    vecs[6]  = '{mk(6, 5, 6, 0, 12'h001),      0, 0, 0, 0, 1, 2, 0, 0,  5,  6,  32'h00000001, 0};
    vecs[7]  = '{mk(1, 0, 9, 1, 12'h456),      0, 0, 0, 0, 0, 0, 1, 0,  0,  0,  32'h00001456, 0};
    vecs[8]  = '{mk(3, 0, 0, 0, 12'h100),      1, 0, 0, 0, 0, 0, 2, 31, 0,  0,  32'h00000100, 0};
    vecs[9]  = '{mk(4, 31, 0, 0, 12'h000),     0, 0, 0, 0, 0, 0, 3, 0,  31, 0,  32'h00000000, 0};
    vecs[10] = '{mk(22, 0, 0, 0, 12'h010),     0, 0, 0, 0, 0, 3, 0, 0,  30, 0,  32'h00000010, 0};
    vecs[11] = '{mk(21, 0, 0, 0, 12'hABC),     1, 0, 0, 0, 0, 0, 0, 30, 0,  0,  32'h00000ABC, 0};
    vecs[12] = '{mk(21, 31, 31, 31, 12'hFFF),  1, 0, 0, 0, 0, 0, 0, 30, 0,  0,  32'h07FFFFFF, 0};
    vecs[13] = '{mk(31, 3, 2, 1, 12'h000),     0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  32'h00001000, 1};
    vecs[14] = '{mk(9, 3, 2, 1, 12'h000),      0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  32'h00001000, 1};
    vecs[15] = '{mk(8, 10, 1, 16, 12'h008),    1, 1, 0, 1, 0, 0, 0, 10, 1,  0,  32'hFFFF0008, 0};
    vecs[16] = '{mk(5, 0, 3, 0, 12'h005),      0, 0, 0, 1, 0, 0, 0, 0,  3,  0,  32'h00000005, 0};
    lw5   = '{mk(8, 5, 1, 0, 12'h008),  1, 1, 0, 1, 0, 0, 0, 5, 1, 0, 32'h00000008, 0};
    add_a = '{mk(0, 6, 5, 1, 12'h000),  1, 0, 0, 0, 0, 0, 0, 6, 5, 1, 32'h00001000, 0};
    add_b = '{mk(0, 7, 1, 5, 12'h000),  1, 0, 0, 0, 0, 0, 0, 7, 1, 5, 32'h00005000, 0};
    addi9 = '{mk(5, 9, 2, 0, 12'h003),  1, 0, 0, 1, 0, 0, 0, 9, 2, 0, 32'h00000003, 0};
    instb = '{mk(0, 4, 9, 9, 12'h000),  1, 0, 0, 0, 0, 0, 0, 4, 9, 9, 32'h00009000, 0};
    radd  = vecs[0];

    // reset: in_ready held low even with a request present
    reset_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = radd.instr; bus.in_pc = 32'h0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    cur_exp = '0;
    #12;
    chk("reset_bundle", 128'(act()), 128'(0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b0;
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // decode table, streamed back to back
    for (int i = 0; i < 17; i++)
      send(vecs[i].instr, 32'h1000 + 32'(i) * 4, to_exp(vecs[i], 32'h1000 + 32'(i) * 4));
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("table_drained", 128'(q.size()), 128'(0));
    @(posedge clock); #1;

    // one-cycle latency for R add
    send(radd.instr, 32'h2000, to_exp(radd, 32'h2000));
    @(negedge clock);
    chk("radd_latency", 128'(bus.out_valid), 128'(1));
    chk("radd_fields", 128'({bus.out_rd, bus.out_rs, bus.out_rt, bus.out_reg_write, bus.out_alu_op}),
        128'({5'd3, 5'd2, 5'd4, 1'b1, 5'd0}));
    @(posedge clock); #1;

    // load-use: once on rs match, once on rt match
    for (int k = 0; k < 2; k++) begin
      vec_t use_v;
      use_v = (k == 0) ? add_a : add_b;
      send(lw5.instr, 32'h3000, to_exp(lw5, 32'h3000));
      cur_exp = to_exp(use_v, 32'h3004);
      bus.in_valid = 1'b1; bus.in_instr = use_v.instr; bus.in_pc = 32'h3004;
      @(negedge clock);
      chk("lu_lw_valid", 128'(bus.out_valid), 128'(1));
      chk("lu_stall_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clock); #1;
      @(negedge clock);
      chk("lu_bubble", 128'(bus.out_valid), 128'(0));
      chk("lu_accept_ready", 128'(bus.in_ready), 128'(1));
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      @(negedge clock);
      chk("lu_use_valid", 128'(bus.out_valid), 128'(1));
      chk("lu_use_rd", 128'(bus.out_rd), 128'(use_v.rd));
      @(posedge clock); #1;
    end

    // backpressure then flush
    bus.out_ready = 1'b0;
    e_a = to_exp(addi9, 32'h4000);
    send(addi9.instr, 32'h4000, e_a);
    cur_exp = to_exp(instb, 32'h4004);
    bus.in_valid = 1'b1; bus.in_instr = instb.instr; bus.in_pc = 32'h4004;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_stable", 128'({bus.out_valid, act()}), 128'({1'b1, e_a}));
      @(posedge clock); #1;
    end
    bus.flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clock); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("flush_dropped", 128'({bus.out_valid, 32'(q.size())}), 128'({1'b0, 32'd0}));
    bus.out_ready = 1'b1;
    @(posedge clock); #1;

`ifdef CTRL_DECODE_PERF_EN
    chk("perf_bubbles", 128'(perf_bubbles), 128'(2));
    chk("perf_flushes", 128'(perf_flushes), 128'(1));
`endif

    // reset while stalled
    bus.out_ready = 1'b0;
    send(addi9.instr, 32'h5000, to_exp(addi9, 32'h5000));
    #3;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_bundle", 128'({bus.out_valid, act()}), 128'(0));
    chk("rst_mid_in_ready", 128'(bus.in_ready), 128'(0));
    @(negedge clock);
    chk("rst_hold_in_ready", 128'(bus.in_ready), 128'(0));
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_after_state", 128'({bus.out_valid, bus.in_ready}), 128'({1'b0, 1'b1}));
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    send(radd.instr, 32'h6000, to_exp(radd, 32'h6000));
    @(negedge clock);
    chk("rst_after_latency", 128'(bus.out_valid), 128'(1));
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("final_drained", 128'(q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered instruction-decode stage between fetch and execute for the 32-bit, 5-bit-opcode ISA.
- Decodes one instruction per cycle into a registered control bundle, with a valid/ready handshake on both sides.
- Adds what the old purely combinational decoder lacked: implicit-register resolution (r30, r31), illegal-opcode flagging, load-use bubble insertion and a synchronous flush.

Parameters:
- PC_W, 32, width of the pc sideband carried with each instruction
- STATUS_REG, 30, register implicitly written by setx and read by bex
- LINK_REG, 31, register implicitly written by jal
- HAZARD_CHECK, 1, 1 = insert load-use bubble; 0 = never stall on hazard

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  pc of instruction
- flush  in  1  discard the held instruction and any incoming one
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  PC_W  registered pc
- out_reg_write  out  1  writes rf
- out_mem_read  out  1  lw
- out_mem_write  out  1  sw
- out_alu_src  out  1  immediate operand
- out_alu_op  out  5  ALU opcode
- out_br_kind  out  2  0 none, 1 bne, 2 blt, 3 bex
- out_jmp_kind  out  2  0 none, 1 j, 2 jal, 3 jr
- out_rd  out  5  destination register
- out_rs  out  5  source A
- out_rt  out  5  source B
- out_imm  out  32  sign-extended instr[16:0]
- out_target  out  27  instr[26:0]
- out_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (async, reset_n=0): every out_* = 0; in_ready = 0 while reset is asserted.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready) && !hazard.
  - Load on accept = in_valid && in_ready. Latency 1 cycle.
  - When out_valid=1 and out_ready=0, all outputs stay stable.
- Fields: opcode = [31:27], rd = [26:22], rs = [21:17], rt = [16:12], aluop = [6:2].
- Decode, by opcode:
  - 00000 R: rd/rs/rt from fields; alu_op = aluop; reg_write = 1.
  - 00101 addi and 01000 lw: alu_src = 1, alu_op = 0, reg_write = 1. lw also sets mem_read.
  - 00111 sw: alu_src = 1, mem_write = 1, rt = rd field (store data).
  - 00010 bne and 00110 blt: rs = rd field, rt = rs field, alu_op = 00001.
  - 00001 j: jmp_kind = 1.
  - 00011 jal: jmp_kind = 2, rd = LINK_REG, reg_write = 1.
  - 00100 jr: jmp_kind = 3, rs = rd field.
  - 10110 bex: br_kind = 3, rs = STATUS_REG.
  - 10101 setx: rd = STATUS_REG, reg_write = 1, imm = zero-extended target.
  - Any other opcode: illegal = 1, all write/mem controls 0.
- Register-field zeroing: unused rd/rs/rt fields are driven 0.
- r0 write suppression: reg_write is forced 0 when rd = 0.
- Hazard (HAZARD_CHECK = 1):
  - hazard = out_valid && out_ready && out_mem_read && out_rd != 0 && in_valid && (incoming rs == out_rd || incoming rt == out_rd), using the incoming instruction's decoded sources.
  - On hazard the register loads a bubble (out_valid ← 0) and the input is not accepted. The next cycle accepts normally, giving exactly one bubble.
- Flush: synchronous, highest priority. At the edge out_valid ← 0 and no input is accepted, regardless of out_ready or hazard.
- Bubble retirement: out_valid=1 && out_ready=1 with no accept → out_valid ← 0.
- Reset mid-stall: the held bundle is lost; no bubble is pending afterwards.

Optional Feature:
- Macro CTRL_DECODE_PERF_EN.
- When defined: extra outputs perf_bubbles[15:0] and perf_flushes[15:0].
  - perf_bubbles increments per inserted hazard bubble; perf_flushes increments per cycle with flush=1 and out_valid=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ctrl_isa_pkg holds:
  - the opcode localparams (OP_ALU, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX);
  - the br_kind and jmp_kind encodings;
  - the field bit positions.
- One combinational sub-module, ctrl_decode_comb (instruction → unregistered bundle plus source registers), instantiated once. The hazard compare uses its rs/rt outputs.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle → all outputs 0 immediately; in_ready=0 until release.
- R add: instr 0x00C44000 (rd=3, rs=2, rt=4, aluop=0) → next cycle out_valid=1, rd=3, rs=2, rt=4, reg_write=1, alu_op=0.
- Load-use: lw r5 followed by add r6 = r5 + r1, with out_ready=1 → one cycle with out_valid=0 between them; add appears 2 cycles after lw.
- Backpressure plus flush: out_ready=0 for 3 cycles → bundle stable and in_ready=0; then flush=1 → out_valid=0 next cycle and the incoming instruction is dropped.
- Implicit registers:
  - jal → rd=31, reg_write=1.
  - setx 0x000ABC → rd=30, imm=0x00000ABC.
  - bex → rs=30, br_kind=3.
  - opcode 11111 → illegal=1, reg_write=0.
- Perf (CTRL_DECODE_PERF_EN): 2 hazards plus 1 flush → perf_bubbles=2, perf_flushes=1.
